// File: rtl/noc_eject_sink_if.sv
// Flit ejection channel: router-to-sink req/ack side and sink-to-core valid/ready side.
interface noc_eject_sink_if #(
    parameter int unsigned DATA_W = 32
);
    logic              in_req;
    logic [DATA_W-1:0] in_data;
    logic              in_ack;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_dst_err;
    logic              out_seq_err;
    logic              out_ready;

    modport master (
        output in_req, in_data, out_ready,
        input  in_ack, out_valid, out_data, out_dst_err, out_seq_err
    );

    modport slave (
        input  in_req, in_data, out_ready,
        output in_ack, out_valid, out_data, out_dst_err, out_seq_err
    );
endinterface

// File: rtl/noc_eject_sink.sv
// Mesh ejection endpoint: buffers incoming flits, tags destination/sequence errors,
// hands them to the local core and keeps saturating status counters.
module noc_eject_sink #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned NODE_X     = 0,
    parameter int unsigned NODE_Y     = 0
) (
    input  logic                clk,
    input  logic                rst,
    noc_eject_sink_if.slave     link,
    input  logic                clr,
    output logic [15:0]         rx_count,
    output logic [15:0]         dst_err_count,
    output logic [15:0]         seq_err_count,
    output logic                err_sticky
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned ENT_W = DATA_W + 2;
    localparam int unsigned NSRC  = 4;
    localparam logic [1:0]  NODE_ID = {1'(NODE_Y), 1'(NODE_X)};

    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic             running;

    logic             seq_valid [NSRC];
    logic [7:0]       last_seq  [NSRC];

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [1:0]       flit_dst;
    logic [1:0]       flit_src;
    logic [7:0]       flit_seq;
    logic             dst_err;
    logic             seq_err;
    logic [ENT_W-1:0] head;
    logic [15:0]      rx_next;
    logic [15:0]      dst_next;
    logic [15:0]      seq_next;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
        return (inc && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    assign full  = (occ == OCC_W'(FIFO_DEPTH));
    assign empty = (occ == '0);

    // running holds in_ack low through reset and for the edge that releases it
    assign link.in_ack = running && !full;
    assign push        = link.in_req && link.in_ack;
    assign pop         = link.out_valid && link.out_ready;

    assign head             = mem[rd_ptr];
    assign link.out_valid   = !empty;
    assign link.out_data    = empty ? '0 : head[DATA_W-1:0];
    assign link.out_dst_err = !empty && head[DATA_W];
    assign link.out_seq_err = !empty && head[DATA_W+1];

    assign flit_dst = link.in_data[29:28];
    assign flit_src = link.in_data[27:26];
    assign flit_seq = link.in_data[7:0];

    // A clear in the same cycle wipes the table before this flit is checked
    always_comb begin
        dst_err = (flit_dst != NODE_ID);
        seq_err = 1'b0;
        if (seq_valid[flit_src] && !clr) begin
            seq_err = (flit_seq != last_seq[flit_src] + 8'd1);
        end
    end

    always_comb begin
        rx_next  = clr ? 16'd0 : rx_count;
        dst_next = clr ? 16'd0 : dst_err_count;
        seq_next = clr ? 16'd0 : seq_err_count;
        if (push) begin
            rx_next  = sat_inc(rx_next, 1'b1);
            dst_next = sat_inc(dst_next, dst_err);
            seq_next = sat_inc(seq_next, seq_err);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {seq_err, dst_err, link.in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            running <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
        end else begin
            running <= 1'b1;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_count      <= '0;
            dst_err_count <= '0;
            seq_err_count <= '0;
            err_sticky    <= 1'b0;
        end else begin
            rx_count      <= rx_next;
            dst_err_count <= dst_next;
            seq_err_count <= seq_next;
            err_sticky    <= (err_sticky && !clr) || (push && (dst_err || seq_err));
        end
    end

    // Every accepted flit resyncs its source entry, errored or not
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSRC; i++) begin
                seq_valid[i] <= 1'b0;
                last_seq[i]  <= '0;
            end
        end else begin
            if (clr) begin
                for (int i = 0; i < NSRC; i++) seq_valid[i] <= 1'b0;
            end
            if (push) begin
                seq_valid[flit_src] <= 1'b1;
                last_seq[flit_src]  <= flit_seq;
            end
        end
    end
endmodule

// File: tb/tb_noc_eject_sink.sv
// Directed bench for noc_eject_sink at node (1,0) with a 4-deep buffer.
module tb_noc_eject_sink;
    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic [15:0] rx_count;
    logic [15:0] dst_err_count;
    logic [15:0] seq_err_count;
    logic        err_sticky;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    noc_eject_sink_if #(.DATA_W(32)) link ();

    noc_eject_sink #(
        .DATA_W(32), .FIFO_DEPTH(4), .NODE_X(1), .NODE_Y(0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .link          (link),
        .clr           (clr),
        .rx_count      (rx_count),
        .dst_err_count (dst_err_count),
        .seq_err_count (seq_err_count),
        .err_sticky    (err_sticky)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one flit alone, then check it at the head and let it drain
    task automatic push_one(input string tag, input logic [31:0] d,
                            input logic exp_dst, input logic exp_seq);
        link.in_req  = 1'b1;
        link.in_data = d;
        tick();
        link.in_req  = 1'b0;
        check({tag, "_valid"}, 32'(link.out_valid), 32'd1);
        check({tag, "_data"}, link.out_data, d);
        check({tag, "_dst"}, 32'(link.out_dst_err), 32'(exp_dst));
        check({tag, "_seq"}, 32'(link.out_seq_err), 32'(exp_seq));
        tick();
    endtask

    logic [31:0] burst [5];
    int          k;
    logic        go;

    initial begin
        rst            = 1'b1;
        clr            = 1'b0;
        link.in_req    = 1'b0;
        link.in_data   = '0;
        link.out_ready = 1'b1;
        tick();
        tick();
        check("rst_ack", 32'(link.in_ack), 32'd0);
        check("rst_valid", 32'(link.out_valid), 32'd0);
        check("rst_data", link.out_data, 32'd0);
        check("rst_rx", 32'(rx_count), 32'd0);
        check("rst_sticky", 32'(err_sticky), 32'd0);
        rst = 1'b0;
        check("ack_held_low", 32'(link.in_ack), 32'd0);
        tick();
        check("ack_rise", 32'(link.in_ack), 32'd1);

        // 1: back-to-back pair, one-cycle latency
        link.in_req  = 1'b1;
        link.in_data = 32'h51929227;
        tick();
        check("t1_f0_valid", 32'(link.out_valid), 32'd1);
        check("t1_f0_data", link.out_data, 32'h51929227);
        link.in_data = 32'h51929228;
        tick();
        check("t1_f1_data", link.out_data, 32'h51929228);
        check("t1_f1_seq", 32'(link.out_seq_err), 32'd0);
        link.in_req = 1'b0;
        tick();
        check("t1_empty", 32'(link.out_valid), 32'd0);
        check("t1_rx", 32'(rx_count), 32'd2);
        check("t1_dcnt", 32'(dst_err_count), 32'd0);
        check("t1_scnt", 32'(seq_err_count), 32'd0);
        check("t1_sticky", 32'(err_sticky), 32'd0);

        // 2: gap in sequence, then resync
        push_one("t2_gap", 32'h5192922A, 1'b0, 1'b1);
        check("t2_scnt", 32'(seq_err_count), 32'd1);
        check("t2_sticky", 32'(err_sticky), 32'd1);
        push_one("t2_resync", 32'h5192922B, 1'b0, 1'b0);
        check("t2_rx", 32'(rx_count), 32'd4);

        // 3: wrong destination after a clear; entry for src0 seeded with 0x27
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_rx", 32'(rx_count), 32'd0);
        check("clr_sticky", 32'(err_sticky), 32'd0);
        push_one("t3_dst", 32'h41929227, 1'b1, 1'b0);
        check("t3_dcnt", 32'(dst_err_count), 32'd1);
        check("t3_sticky", 32'(err_sticky), 32'd1);
        push_one("t3_next", 32'h51929228, 1'b0, 1'b0);
        check("t3_scnt", 32'(seq_err_count), 32'd0);

        // 4: stalled core, five flits offered to a four-deep buffer
        burst[0] = 32'h55929201;
        burst[1] = 32'h55929202;
        burst[2] = 32'h55929203;
        burst[3] = 32'h55929204;
        burst[4] = 32'h55929205;
        link.out_ready = 1'b0;
        link.in_req    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            link.in_data = burst[i];
            tick();
        end
        link.in_data = burst[4];
        check("t4_full_ack", 32'(link.in_ack), 32'd0);
        tick();
        tick();
        check("t4_still_full", 32'(link.in_ack), 32'd0);
        check("t4_head", link.out_data, burst[0]);
        check("t4_rx", 32'(rx_count), 32'd6);
        link.out_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 12; c++) begin
            if (link.out_valid) begin
                check("t4_order", link.out_data, (k < 5) ? burst[k] : 32'hDEAD0000);
                check("t4_seq", 32'(link.out_seq_err), 32'd0);
                k++;
            end
            go = link.in_req && link.in_ack;
            tick();
            if (go) link.in_req = 1'b0;
        end
        check("t4_drained", 32'(k), 32'd5);
        check("t4_rx_end", 32'(rx_count), 32'd7);

        // 5: sequence wrap and first flit from a new source
        clr = 1'b1;
        tick();
        clr = 1'b0;
        push_one("t5_ff", 32'h519292FF, 1'b0, 1'b0);
        push_one("t5_wrap", 32'h51929200, 1'b0, 1'b0);
        push_one("t5_src2", 32'h59929210, 1'b0, 1'b0);
        check("t5_scnt", 32'(seq_err_count), 32'd0);
        check("t5_rx", 32'(rx_count), 32'd3);

        // 6: reset with flits buffered, then clear coincident with an accept
        link.out_ready = 1'b0;
        link.in_req    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            link.in_data = burst[i];
            tick();
        end
        link.in_req = 1'b0;
        check("t6_rx_pre", 32'(rx_count), 32'd6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        link.out_ready = 1'b1;
        check("t6_valid", 32'(link.out_valid), 32'd0);
        check("t6_rx", 32'(rx_count), 32'd0);
        check("t6_ack", 32'(link.in_ack), 32'd0);
        tick();
        push_one("t6_a", 32'h51929240, 1'b0, 1'b0);
        push_one("t6_b", 32'h51929241, 1'b0, 1'b0);
        clr          = 1'b1;
        link.in_req  = 1'b1;
        link.in_data = 32'h41929230;
        tick();
        clr         = 1'b0;
        link.in_req = 1'b0;
        check("t6_clr_rx", 32'(rx_count), 32'd1);
        check("t6_clr_dcnt", 32'(dst_err_count), 32'd1);
        check("t6_clr_scnt", 32'(seq_err_count), 32'd0);
        check("t6_clr_head_seq", 32'(link.out_seq_err), 32'd0);
        tick();
        push_one("t6_seeded", 32'h51929231, 1'b0, 1'b0);
        push_one("t6_break", 32'h51929233, 1'b0, 1'b1);
        check("t6_scnt", 32'(seq_err_count), 32'd1);
        check("t6_rx_end", 32'(rx_count), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
